axi_write_arb: RTL and testbench

Round-robin arbiter that shares one AXI write master command/stream channel among ARB_NUM requesters. Each requester issues a write command (addr, len) plus an AXI-stream data burst. The arbiter serializes whole transactions (command, data, completion) onto the single master port. It sits between accelerator write engines and the AXI write master; it is the write-side companion of the read arbiter.

---
 rtl/axi_write_arb_pkg.sv | 28 ++
 rtl/axi_rr_pick.sv | 30 +++
 rtl/axi_write_arb.sv | 132 +++++++++++++
 tb/tb_axi_write_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_write_arb_pkg.sv
// Shared types and helpers for the AXI write arbiter slice.
package axi_write_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module axi_rr_pick
  import axi_write_arb_pkg::*;
#(
  parameter int ARB_NUM = 3,
  parameter int IDX_W   = idx_width(ARB_NUM)
) (
  input  logic [ARB_NUM-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan ARB_NUM positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned pos;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < ARB_NUM; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= ARB_NUM) pos = pos - ARB_NUM;
      if (!valid && req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_write_arb.sv
// Round-robin arbiter serializing whole write transactions onto one AXI write master.
module axi_write_arb
  import axi_write_arb_pkg::*;
#(
  parameter int AXI_ADDR_BITWIDTH = 29,
  parameter int AXI_DATA_BITWIDTH = 128,
  parameter int ARB_NUM           = 3
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst,
  input  logic [ARB_NUM-1:0]                     write_cmd_start,
  input  logic [ARB_NUM*AXI_ADDR_BITWIDTH-1:0]   write_cmd_addr,
  input  logic [ARB_NUM*AXI_ADDR_BITWIDTH-1:0]   write_cmd_len,
  output logic [ARB_NUM-1:0]                     write_cmd_ack,
  output logic [ARB_NUM-1:0]                     write_cmd_done,
  input  logic [ARB_NUM-1:0]                     write_axis_valid,
  input  logic [ARB_NUM-1:0]                     write_axis_last,
  input  logic [ARB_NUM*AXI_DATA_BITWIDTH-1:0]   write_axis_data,
  output logic [ARB_NUM-1:0]                     write_axis_ready,
  output logic                                   arb_write_cmd_start,
  input  logic                                   arb_write_cmd_ready,
  output logic [AXI_ADDR_BITWIDTH-1:0]           arb_write_cmd_addr,
  output logic [AXI_ADDR_BITWIDTH-1:0]           arb_write_cmd_len,
  input  logic                                   arb_write_cmd_done,
  output logic                                   arb_write_axis_valid,
  output logic                                   arb_write_axis_last,
  output logic [AXI_DATA_BITWIDTH-1:0]           arb_write_axis_data,
  input  logic                                   arb_write_axis_ready
);

  localparam int IDX_W = idx_width(ARB_NUM);

  arb_state_t                   state, state_nxt;
  logic [IDX_W-1:0]             grant, grant_nxt;
  logic [IDX_W-1:0]             ptr, ptr_nxt;
  logic [IDX_W-1:0]             pick_idx;
  logic                         pick_valid;
  logic [AXI_ADDR_BITWIDTH-1:0] addr_q, addr_nxt;
  logic [AXI_ADDR_BITWIDTH-1:0] len_q, len_nxt;
  logic [ARB_NUM-1:0]           ack_q, ack_nxt;
  logic [ARB_NUM-1:0]           done_q, done_nxt;
  logic                         beat_last;
  logic                         finish;

  axi_rr_pick #(
    .ARB_NUM (ARB_NUM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (write_cmd_start),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign arb_write_cmd_start = (state == CMD);
  assign arb_write_cmd_addr  = addr_q;
  assign arb_write_cmd_len   = len_q;
  assign write_cmd_ack       = ack_q;
  assign write_cmd_done      = done_q;

  // Zero-latency stream mux from the granted requester, only while in DATA.
  always_comb begin
    arb_write_axis_valid = 1'b0;
    arb_write_axis_last  = 1'b0;
    arb_write_axis_data  = '0;
    write_axis_ready     = '0;
    if (state == DATA) begin
      arb_write_axis_valid    = write_axis_valid[grant];
      arb_write_axis_last     = write_axis_last[grant];
      arb_write_axis_data     = write_axis_data[grant*AXI_DATA_BITWIDTH +: AXI_DATA_BITWIDTH];
      write_axis_ready[grant] = arb_write_axis_ready;
    end
  end

  assign beat_last = arb_write_axis_valid & arb_write_axis_ready & arb_write_axis_last;

  // A response coincident with the final beat completes the transaction directly from DATA.
  assign finish = arb_write_cmd_done & ((state == RESP) | ((state == DATA) & beat_last));

  // Next-state, grant/pointer update, command latch and handshake pulses.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    addr_nxt  = addr_q;
    len_nxt   = len_q;
    ack_nxt   = '0;
    done_nxt  = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt         = pick_idx;
          addr_nxt          = write_cmd_addr[pick_idx*AXI_ADDR_BITWIDTH +: AXI_ADDR_BITWIDTH];
          len_nxt           = write_cmd_len[pick_idx*AXI_ADDR_BITWIDTH +: AXI_ADDR_BITWIDTH];
          ack_nxt[pick_idx] = 1'b1;
          state_nxt         = CMD;
        end
      end
      CMD:     if (arb_write_cmd_ready) state_nxt = DATA;
      DATA:    if (beat_last) state_nxt = RESP;
      RESP:    state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
    if (finish) begin
      done_nxt[grant] = 1'b1;
      ptr_nxt         = (grant == IDX_W'(ARB_NUM - 1)) ? '0 : grant + 1'b1;
      state_nxt       = IDLE;
    end
  end

  // State and datapath registers; reset aborts any transaction silently.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state  <= IDLE;
      grant  <= '0;
      ptr    <= '0;
      addr_q <= '0;
      len_q  <= '0;
      ack_q  <= '0;
      done_q <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      ptr    <= ptr_nxt;
      addr_q <= addr_nxt;
      len_q  <= len_nxt;
      ack_q  <= ack_nxt;
      done_q <= done_nxt;
    end
  end

endmodule

// File: tb/tb_axi_write_arb.sv
// Directed scoreboard bench for axi_write_arb with per-cycle protocol checks.
module tb_axi_write_arb;

  localparam int AW = 29;
  localparam int DW = 128;
  localparam int N  = 3;

  typedef struct {
    int            r;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    int            nbeats;
    logic [DW-1:0] base;
  } txn_t;

  logic            sys_clk;
  logic            sys_rst;
  logic [N-1:0]    write_cmd_start;
  logic [N*AW-1:0] write_cmd_addr;
  logic [N*AW-1:0] write_cmd_len;
  logic [N-1:0]    write_cmd_ack;
  logic [N-1:0]    write_cmd_done;
  logic [N-1:0]    write_axis_valid;
  logic [N-1:0]    write_axis_last;
  logic [N*DW-1:0] write_axis_data;
  logic [N-1:0]    write_axis_ready;
  logic            arb_write_cmd_start;
  logic            arb_write_cmd_ready;
  logic [AW-1:0]   arb_write_cmd_addr;
  logic [AW-1:0]   arb_write_cmd_len;
  logic            arb_write_cmd_done;
  logic            arb_write_axis_valid;
  logic            arb_write_axis_last;
  logic [DW-1:0]   arb_write_axis_data;
  logic            arb_write_axis_ready;

  axi_write_arb #(
    .AXI_ADDR_BITWIDTH (AW),
    .AXI_DATA_BITWIDTH (DW),
    .ARB_NUM           (N)
  ) dut (
    .sys_clk              (sys_clk),
    .sys_rst              (sys_rst),
    .write_cmd_start      (write_cmd_start),
    .write_cmd_addr       (write_cmd_addr),
    .write_cmd_len        (write_cmd_len),
    .write_cmd_ack        (write_cmd_ack),
    .write_cmd_done       (write_cmd_done),
    .write_axis_valid     (write_axis_valid),
    .write_axis_last      (write_axis_last),
    .write_axis_data      (write_axis_data),
    .write_axis_ready     (write_axis_ready),
    .arb_write_cmd_start  (arb_write_cmd_start),
    .arb_write_cmd_ready  (arb_write_cmd_ready),
    .arb_write_cmd_addr   (arb_write_cmd_addr),
    .arb_write_cmd_len    (arb_write_cmd_len),
    .arb_write_cmd_done   (arb_write_cmd_done),
    .arb_write_axis_valid (arb_write_axis_valid),
    .arb_write_axis_last  (arb_write_axis_last),
    .arb_write_axis_data  (arb_write_axis_data),
    .arb_write_axis_ready (arb_write_axis_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Scoreboards: commands in expected grant order, beats in expected transfer order.
  txn_t          cmd_q[$];
  logic [DW:0]   beat_q[$];
  txn_t          rq_q[N][$];

  // Requester driver state: 0 free, 1 requesting, 2 streaming, 3 awaiting done.
  int            d_state[N];
  int            d_idx[N];
  txn_t          d_txn[N];
  int            raise_cyc[N];
  bit            hs[N];
  bit            ack_seen[N];
  bit            done_seen[N];

  // Transaction model: phase 0 idle, 1 command, 2 data, 3 response.
  int            cyc = 0;
  int            idle_cyc = 0;
  bit            busy = 0;
  int            phase = 0;
  txn_t          cur;
  logic [N-1:0]  exp_done = '0;
  int            completed = 0;

  // Master-side behaviour knobs.
  int            cmd_lat = 0;
  int            start_cnt = 0;
  int            resp_lat = 1;
  int            resp_cnt = 0;
  bit            toggle_ready = 0;
  bit            coincide = 0;
  bit            spur_done = 0;

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_txn(input int r, input logic [AW-1:0] a, input logic [AW-1:0] l,
                         input int nb, input logic [DW-1:0] base);
    txn_t t;
    t.r = r; t.addr = a; t.len = l; t.nbeats = nb; t.base = base;
    cmd_q.push_back(t);
    rq_q[r].push_back(t);
    for (int k = 0; k < nb; k++) beat_q.push_back({(k == nb - 1), base + DW'(k)});
  endtask

  task automatic drive_requesters();
    for (int i = 0; i < N; i++) begin
      if (d_state[i] == 3 && done_seen[i]) d_state[i] = 0;
      if (d_state[i] == 2 && hs[i]) begin
        d_idx[i]++;
        if (d_idx[i] == d_txn[i].nbeats) begin
          write_axis_valid[i] = 1'b0;
          write_axis_last[i]  = 1'b0;
          d_state[i]          = 3;
        end else begin
          write_axis_data[i*DW +: DW] = d_txn[i].base + DW'(d_idx[i]);
          write_axis_last[i]          = (d_idx[i] == d_txn[i].nbeats - 1);
        end
      end
      if (d_state[i] == 1 && ack_seen[i]) begin
        write_cmd_start[i]          = 1'b0;
        write_axis_valid[i]         = 1'b1;
        write_axis_data[i*DW +: DW] = d_txn[i].base;
        write_axis_last[i]          = (d_txn[i].nbeats == 1);
        d_idx[i]                    = 0;
        d_state[i]                  = 2;
      end
      if (d_state[i] == 0 && rq_q[i].size() > 0) begin
        d_txn[i]                   = rq_q[i].pop_front();
        write_cmd_addr[i*AW +: AW] = d_txn[i].addr;
        write_cmd_len[i*AW +: AW]  = d_txn[i].len;
        write_cmd_start[i]         = 1'b1;
        raise_cyc[i]               = cyc;
        d_state[i]                 = 1;
      end
    end
  endtask

  // One clock: check outputs at the falling edge, then drive inputs just after the rising edge.
  task automatic step();
    logic        last_hs;
    logic [DW:0] beat;
    @(negedge sys_clk);
    if (coincide && arb_write_axis_valid && arb_write_axis_ready && arb_write_axis_last)
      arb_write_cmd_done = 1'b1;
    chk("ready_onehot0", $onehot0(write_axis_ready), 1);
    chk("done_vec", write_cmd_done, exp_done);
    if (exp_done != '0) begin
      busy = 0; phase = 0; idle_cyc = cyc; completed++;
    end
    if (write_cmd_ack != '0) begin
      chk("ack_expected", (cmd_q.size() > 0) && !busy, 1);
      if (cmd_q.size() > 0 && !busy) begin
        cur = cmd_q.pop_front();
        chk("ack_vec", write_cmd_ack, oh(cur.r));
        chk("ack_cycle", cyc, ((raise_cyc[cur.r] > idle_cyc) ? raise_cyc[cur.r] : idle_cyc) + 1);
        busy = 1; phase = 1; start_cnt = 0;
      end
    end
    if (phase != 2) begin
      chk("no_stream_outside_data", {arb_write_axis_valid, write_axis_ready}, '0);
    end else begin
      chk("mux_valid", arb_write_axis_valid, write_axis_valid[cur.r]);
      chk("mux_ready", write_axis_ready, oh(cur.r) & {N{arb_write_axis_ready}});
    end
    chk("cmd_start_phase", arb_write_cmd_start, phase == 1);
    if (arb_write_cmd_start && phase == 1) begin
      chk("cmd_addr", arb_write_cmd_addr, cur.addr);
      chk("cmd_len", arb_write_cmd_len, cur.len);
      start_cnt++;
    end
    last_hs = 1'b0;
    if (arb_write_axis_valid && arb_write_axis_ready) begin
      chk("beat_expected", beat_q.size() > 0, 1);
      if (beat_q.size() > 0) begin
        beat = beat_q.pop_front();
        chk("beat_data", arb_write_axis_data, beat[DW-1:0]);
        chk("beat_last", arb_write_axis_last, beat[DW]);
      end
      if (arb_write_axis_last && phase == 2) begin
        phase = 3; last_hs = 1'b1;
      end
    end
    exp_done = (arb_write_cmd_done && phase == 3) ? oh(cur.r) : '0;
    if (arb_write_cmd_start && arb_write_cmd_ready && phase == 1) phase = 2;
    for (int i = 0; i < N; i++) begin
      hs[i]        = write_axis_valid[i] & write_axis_ready[i];
      ack_seen[i]  = write_cmd_ack[i];
      done_seen[i] = write_cmd_done[i];
    end
    if (last_hs && !coincide) resp_cnt = resp_lat;

    @(posedge sys_clk);
    cyc++;
    #1;
    arb_write_cmd_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) arb_write_cmd_done = 1'b1;
    end
    if (spur_done && phase == 1 && start_cnt == 2) arb_write_cmd_done = 1'b1;
    arb_write_cmd_ready = (phase == 1) ? (start_cnt >= cmd_lat) : (cmd_lat == 0);
    if (toggle_ready) arb_write_axis_ready = ~arb_write_axis_ready;
    drive_requesters();
  endtask

  function automatic bit quiet();
    bit q;
    q = (cmd_q.size() == 0) && (beat_q.size() == 0) && !busy;
    for (int i = 0; i < N; i++) if (d_state[i] != 0 || rq_q[i].size() != 0) q = 0;
    return q;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!quiet() && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", quiet(), 1);
  endtask

  task automatic reset_bench();
    cmd_q.delete();
    beat_q.delete();
    for (int i = 0; i < N; i++) begin
      rq_q[i].delete();
      d_state[i] = 0; hs[i] = 0; ack_seen[i] = 0; done_seen[i] = 0;
    end
    write_cmd_start = '0; write_axis_valid = '0; write_axis_last = '0;
    write_cmd_addr  = '0; write_cmd_len    = '0; write_axis_data = '0;
    arb_write_cmd_done = 1'b0;
    busy = 0; phase = 0; exp_done = '0; resp_cnt = 0;
  endtask

  task automatic release_reset();
    repeat (2) step();
    sys_rst  = 1'b0;
    idle_cyc = cyc;
  endtask

  initial begin
    int n;
    sys_rst              = 1'b1;
    arb_write_cmd_ready  = 1'b1;
    arb_write_axis_ready = 1'b1;
    reset_bench();
    #1;
    chk("reset_outputs_zero", {arb_write_cmd_start, arb_write_cmd_addr, arb_write_cmd_len,
        arb_write_axis_valid, arb_write_axis_last, arb_write_axis_data,
        write_cmd_ack, write_cmd_done, write_axis_ready}, '0);
    step();
    release_reset();

    // Single requester, 4 beats, command ready tied high.
    add_txn(1, 29'h100, 29'd64, 4, 128'h1000);
    wait_idle(100);

    // All three requesting continuously from reset: grants 0,1,2,0,1,2.
    sys_rst = 1'b1;
    reset_bench();
    release_reset();
    resp_lat = 2;
    add_txn(0, 29'h0A00, 29'd32, 2, 128'h2000);
    add_txn(1, 29'h0B00, 29'd32, 2, 128'h2100);
    add_txn(2, 29'h0C00, 29'd32, 2, 128'h2200);
    add_txn(0, 29'h0A40, 29'd32, 2, 128'h2300);
    add_txn(1, 29'h0B40, 29'd32, 2, 128'h2400);
    add_txn(2, 29'h0C40, 29'd32, 2, 128'h2500);
    wait_idle(400);
    resp_lat = 1;

    // Command ready held low 5 cycles, with a stray done during the command phase.
    cmd_lat   = 5;
    spur_done = 1;
    add_txn(0, 29'h2000, 29'd32, 2, 128'h3000);
    wait_idle(100);
    cmd_lat   = 0;
    spur_done = 0;

    // Stream backpressure alternating every cycle; data 0xA..0xD.
    toggle_ready = 1;
    add_txn(1, 29'h3000, 29'd64, 4, 128'hA);
    wait_idle(100);
    toggle_ready         = 0;
    arb_write_axis_ready = 1'b1;

    // Done coincident with the last beat, then contention to confirm the pointer moved to 0.
    coincide = 1;
    add_txn(2, 29'h4000, 29'd16, 1, 128'h55);
    wait_idle(100);
    add_txn(0, 29'h4100, 29'd16, 2, 128'h60);
    add_txn(2, 29'h4200, 29'd16, 1, 128'h70);
    wait_idle(200);
    coincide = 0;

    // Move the pointer off 0, then reset asynchronously in the middle of a data burst.
    add_txn(1, 29'h5000, 29'd16, 1, 128'h80);
    wait_idle(100);
    toggle_ready = 1;
    add_txn(2, 29'h6000, 29'd128, 8, 128'h90);
    n = 0;
    while (!(phase == 2 && beat_q.size() <= 6) && n < 100) begin
      step();
      n++;
    end
    chk("reached_mid_data", phase == 2 && beat_q.size() <= 6, 1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("async_reset_outputs_zero", {arb_write_cmd_start, arb_write_cmd_addr, arb_write_cmd_len,
        arb_write_axis_valid, arb_write_axis_last, arb_write_axis_data,
        write_cmd_ack, write_cmd_done, write_axis_ready}, '0);
    toggle_ready         = 0;
    arb_write_axis_ready = 1'b1;
    reset_bench();
    release_reset();
    add_txn(0, 29'h7000, 29'd16, 1, 128'hB0);
    add_txn(2, 29'h7100, 29'd16, 1, 128'hC0);
    wait_idle(200);

    chk("completed_count", completed, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
